// File: rtl/bcd_time_counter_pkg.sv
// Shared constants for the hh:mm:ss BCD time word: digit range limits, field
// offsets within the 24-bit word, and the range check used when loading a time.
package bcd_time_counter_pkg;

    localparam logic [3:0] DIGIT_MAX           = 4'd9;
    localparam logic [3:0] SEC_TENS_MAX        = 4'd5;
    localparam logic [3:0] MIN_TENS_MAX        = 4'd5;
    localparam logic [3:0] HOUR_MAX_TENS       = 4'd2;
    localparam logic [3:0] HOUR_MAX_UNITS_AT_2 = 4'd3;

    localparam int unsigned S1_LSB  = 0;
    localparam int unsigned S10_LSB = 4;
    localparam int unsigned M1_LSB  = 8;
    localparam int unsigned M10_LSB = 12;
    localparam int unsigned H1_LSB  = 16;
    localparam int unsigned H10_LSB = 20;

    function automatic logic time_word_valid(input logic [23:0] t);
        logic ok;
        ok = (t[S1_LSB  +: 4] <= DIGIT_MAX)    &&
             (t[S10_LSB +: 4] <= SEC_TENS_MAX) &&
             (t[M1_LSB  +: 4] <= DIGIT_MAX)    &&
             (t[M10_LSB +: 4] <= MIN_TENS_MAX) &&
             (t[H1_LSB  +: 4] <= DIGIT_MAX)    &&
             (t[H10_LSB +: 4] <= HOUR_MAX_TENS);
        if (t[H10_LSB +: 4] == HOUR_MAX_TENS) begin
            ok = ok && (t[H1_LSB +: 4] <= HOUR_MAX_UNITS_AT_2);
        end else begin
            ok = ok;
        end
        return ok;
    endfunction

endpackage

// File: rtl/bcd_time_counter_digit.sv
// One BCD digit: load has priority over increment; wraps MAX -> 0 and flags carry.
module bcd_digit_counter
    import bcd_time_counter_pkg::*;
#(
    parameter logic [3:0] MAX = DIGIT_MAX
) (
    input  logic       clk,
    input  logic       resett,
    input  logic       inc_i,
    input  logic       load_i,
    input  logic [3:0] load_val_i,
    output logic [3:0] digit_o,
    output logic       carry_o
);

    logic [3:0] digit_q;
    logic [3:0] digit_d;

    always_comb begin
        digit_d = digit_q;
        if (load_i) begin
            digit_d = load_val_i;
        end else if (inc_i) begin
            digit_d = (digit_q >= MAX) ? 4'd0 : digit_q + 4'd1;
        end else begin
            digit_d = digit_q;
        end
    end

    always_ff @(posedge clk) begin
        if (resett) begin
            digit_q <= 4'd0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign carry_o = inc_i && (digit_q >= MAX);
    assign digit_o = digit_q;

endmodule

// File: rtl/bcd_time_counter.sv
// Timekeeping core: 1 Hz prescaler, six cascaded BCD digits with 23:59:59 wrap,
// and a range-checked single-cycle time preset with ack/err pulses.
module bcd_time_counter
    import bcd_time_counter_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic        clk,
    input  logic        resett,
    input  logic        run,
    input  logic        set_valid,
    input  logic [23:0] set_time,
    output logic        set_ack,
    output logic        set_err,
    output logic        sec_pulse,
    output logic [3:0]  h10,
    output logic [3:0]  h1,
    output logic [3:0]  m10,
    output logic [3:0]  m1,
    output logic [3:0]  s10,
    output logic [3:0]  s1
);

    localparam int PW = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic          set_ack_q, set_err_q, sec_pulse_q;
    logic          set_ok_s, set_load_s, tick_s, tick_eff_s;
    logic          s1_c_s, s10_c_s, m1_c_s, m10_c_s, h1_c_s, h10_c_s;
    logic          hour_wrap_s, hour_load_s;
    logic [3:0]    h1_val_s, h10_val_s;

    assign set_ok_s   = time_word_valid(set_time);
    assign set_load_s = set_valid && set_ok_s;
    assign tick_s     = run && (presc_q == PRESC_MAX);
    // An accepted preset swallows a coincident tick so the new time starts a full second.
    assign tick_eff_s = tick_s && !set_load_s;

    always_comb begin
        presc_d = presc_q;
        if (set_load_s) begin
            presc_d = '0;
        end else if (tick_s) begin
            presc_d = '0;
        end else if (run) begin
            presc_d = presc_q + PW'(1);
        end else begin
            presc_d = presc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (resett) begin
            presc_q     <= '0;
            set_ack_q   <= 1'b0;
            set_err_q   <= 1'b0;
            sec_pulse_q <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            set_ack_q   <= set_valid && set_ok_s;
            set_err_q   <= set_valid && !set_ok_s;
            sec_pulse_q <= tick_eff_s;
        end
    end

    // Hours wrap 23 -> 00 here; a carry out of the tens digit is also forced back to 00.
    assign hour_wrap_s = (m10_c_s && (h10 == HOUR_MAX_TENS) && (h1 == HOUR_MAX_UNITS_AT_2)) || h10_c_s;
    assign hour_load_s = set_load_s || hour_wrap_s;
    assign h1_val_s    = set_load_s ? set_time[H1_LSB  +: 4] : 4'd0;
    assign h10_val_s   = set_load_s ? set_time[H10_LSB +: 4] : 4'd0;

    bcd_digit_counter #(.MAX(DIGIT_MAX)) u_s1 (
        .clk(clk), .resett(resett), .inc_i(tick_eff_s), .load_i(set_load_s),
        .load_val_i(set_time[S1_LSB +: 4]), .digit_o(s1), .carry_o(s1_c_s));

    bcd_digit_counter #(.MAX(SEC_TENS_MAX)) u_s10 (
        .clk(clk), .resett(resett), .inc_i(s1_c_s), .load_i(set_load_s),
        .load_val_i(set_time[S10_LSB +: 4]), .digit_o(s10), .carry_o(s10_c_s));

    bcd_digit_counter #(.MAX(DIGIT_MAX)) u_m1 (
        .clk(clk), .resett(resett), .inc_i(s10_c_s), .load_i(set_load_s),
        .load_val_i(set_time[M1_LSB +: 4]), .digit_o(m1), .carry_o(m1_c_s));

    bcd_digit_counter #(.MAX(MIN_TENS_MAX)) u_m10 (
        .clk(clk), .resett(resett), .inc_i(m1_c_s), .load_i(set_load_s),
        .load_val_i(set_time[M10_LSB +: 4]), .digit_o(m10), .carry_o(m10_c_s));

    bcd_digit_counter #(.MAX(DIGIT_MAX)) u_h1 (
        .clk(clk), .resett(resett), .inc_i(m10_c_s), .load_i(hour_load_s),
        .load_val_i(h1_val_s), .digit_o(h1), .carry_o(h1_c_s));

    bcd_digit_counter #(.MAX(HOUR_MAX_TENS)) u_h10 (
        .clk(clk), .resett(resett), .inc_i(h1_c_s), .load_i(hour_load_s),
        .load_val_i(h10_val_s), .digit_o(h10), .carry_o(h10_c_s));

    assign set_ack   = set_ack_q;
    assign set_err   = set_err_q;
    assign sec_pulse = sec_pulse_q;

endmodule
